// File: rtl/branch_predict_unit.sv
// ---------------------------------------------------------------------------
// branch_predict_unit
//   Resolves BEQZ/BNEZ/BLTZ/BGEZ in execute against the signed Rs value, trains
//   a direct-mapped table of 2-bit saturating predictors, and keeps saturating
//   counts of resolved and mispredicted branches.
//
// Ports
//   clk_i, rst_i          clock, synchronous active-high reset
//   fet_pc_i              fetch PC; table index = fet_pc_i[IDX_W:1]
//   pred_taken_o          combinational prediction for the fetch PC
//   ex_valid_i            execute holds a candidate branch
//   ex_opcode_i           5-bit opcode of that instruction
//   ex_rs_data_i          Rs value, two's complement
//   ex_pc_i               branch PC; update index = ex_pc_i[IDX_W:1]
//   ex_pred_taken_i       prediction carried down from fetch
//   ex_stall_i            execute stalled: nothing resolves, trains or counts
//   clr_stats_i           clear both statistics counters
//   res_valid_o           one-cycle pulse: a branch resolved last cycle
//   res_taken_o           actual outcome (0 when res_valid_o = 0)
//   res_mispredict_o      outcome differed from carried prediction
//   br_count_o            resolved branches, saturating
//   mis_count_o           mispredicted branches, saturating
//
// Entry FSM
//   state | meaning
//   SNT   | strongly not taken
//   WNT   | weakly not taken
//   WT    | weakly taken
//   ST    | strongly taken
// ---------------------------------------------------------------------------
module branch_predict_unit #(
  parameter int          DATA_W     = 16,
  parameter int          IDX_W      = 4,
  parameter int          CNT_W      = 16,
  parameter logic [1:0]  INIT_STATE = 2'b01
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [DATA_W-1:0] fet_pc_i,
  output logic              pred_taken_o,
  input  logic              ex_valid_i,
  input  logic [4:0]        ex_opcode_i,
  input  logic [DATA_W-1:0] ex_rs_data_i,
  input  logic [DATA_W-1:0] ex_pc_i,
  input  logic              ex_pred_taken_i,
  input  logic              ex_stall_i,
  input  logic              clr_stats_i,
  output logic              res_valid_o,
  output logic              res_taken_o,
  output logic              res_mispredict_o,
  output logic [CNT_W-1:0]  br_count_o,
  output logic [CNT_W-1:0]  mis_count_o
);

  localparam int ENTRIES = 1 << IDX_W;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } pstate_e;

  pstate_e           table_q [ENTRIES];
  pstate_e           table_d [ENTRIES];
  logic              res_valid_q, res_valid_d;
  logic              res_taken_q, res_taken_d;
  logic              res_mis_q, res_mis_d;
  logic [CNT_W-1:0]  br_cnt_q, br_cnt_d;
  logic [CNT_W-1:0]  mis_cnt_q, mis_cnt_d;

  logic [IDX_W-1:0]  fet_idx;
  logic [IDX_W-1:0]  ex_idx;
  logic              is_branch;
  logic              resolve;
  logic              taken;
  logic              mispredict;
  pstate_e           cur_state;
  pstate_e           new_state;

  // Bit 0 and bits above the index are halfword offset / tag bits this table ignores.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{fet_pc_i, ex_pc_i};

  assign fet_idx = fet_pc_i[IDX_W:1];
  assign ex_idx  = ex_pc_i[IDX_W:1];

  // No bypass: fetch sees the registered entry even if execute is updating it.
  assign pred_taken_o = table_q[fet_idx][1];

  always_comb begin
    is_branch = (ex_opcode_i[4:2] == 3'b011);
    resolve   = ex_valid_i & ~ex_stall_i & is_branch;

    // Low two opcode bits select the condition; LTZ/GEZ look only at the sign bit.
    unique case (ex_opcode_i[1:0])
      2'b00:   taken = (ex_rs_data_i == '0);
      2'b01:   taken = (ex_rs_data_i != '0);
      2'b10:   taken = ex_rs_data_i[DATA_W-1];
      default: taken = ~ex_rs_data_i[DATA_W-1];
    endcase

    mispredict = taken ^ ex_pred_taken_i;
    cur_state  = table_q[ex_idx];

    new_state = cur_state;
    if (taken) begin
      if (cur_state != ST) new_state = pstate_e'(cur_state + 2'b01);
    end else begin
      if (cur_state != SNT) new_state = pstate_e'(cur_state - 2'b01);
    end
  end

  always_comb begin
    table_d = table_q;
    if (resolve) table_d[ex_idx] = new_state;

    res_valid_d = resolve;
    res_taken_d = resolve & taken;
    res_mis_d   = resolve & mispredict;

    br_cnt_d  = br_cnt_q;
    mis_cnt_d = mis_cnt_q;
    if (clr_stats_i) begin
      br_cnt_d  = '0;
      mis_cnt_d = '0;
    end else if (resolve) begin
      if (br_cnt_q != '1) br_cnt_d = br_cnt_q + 1'b1;
      if (mispredict && (mis_cnt_q != '1)) mis_cnt_d = mis_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < ENTRIES; i++) table_q[i] <= pstate_e'(INIT_STATE);
      res_valid_q <= 1'b0;
      res_taken_q <= 1'b0;
      res_mis_q   <= 1'b0;
      br_cnt_q    <= '0;
      mis_cnt_q   <= '0;
    end else begin
      table_q     <= table_d;
      res_valid_q <= res_valid_d;
      res_taken_q <= res_taken_d;
      res_mis_q   <= res_mis_d;
      br_cnt_q    <= br_cnt_d;
      mis_cnt_q   <= mis_cnt_d;
    end
  end

  assign res_valid_o      = res_valid_q;
  assign res_taken_o      = res_taken_q;
  assign res_mispredict_o = res_mis_q;
  assign br_count_o       = br_cnt_q;
  assign mis_count_o      = mis_cnt_q;

endmodule

// File: tb/tb_branch_predict_unit.sv
// ---------------------------------------------------------------------------
// tb_branch_predict_unit
//   Directed bench for branch_predict_unit. Two instances share all inputs:
//   the default build (CNT_W=16) and a CNT_W=2 build for counter saturation.
// ---------------------------------------------------------------------------
module tb_branch_predict_unit;

  localparam logic [4:0] OP_BEQZ = 5'b01100;
  localparam logic [4:0] OP_BNEZ = 5'b01101;
  localparam logic [4:0] OP_BLTZ = 5'b01110;
  localparam logic [4:0] OP_BGEZ = 5'b01111;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] fet_pc;
  logic        ex_valid;
  logic [4:0]  ex_opcode;
  logic [15:0] ex_rs_data;
  logic [15:0] ex_pc;
  logic        ex_pred_taken;
  logic        ex_stall;
  logic        clr_stats;

  logic        pred_taken, res_valid, res_taken, res_mis;
  logic [15:0] br_count, mis_count;
  logic        pred_taken2, res_valid2, res_taken2, res_mis2;
  logic [1:0]  br_count2, mis_count2;

  always #5 clk = ~clk;

  branch_predict_unit #(.DATA_W(16), .IDX_W(4), .CNT_W(16), .INIT_STATE(2'b01)) dut (
    .clk_i(clk), .rst_i(rst), .fet_pc_i(fet_pc), .pred_taken_o(pred_taken),
    .ex_valid_i(ex_valid), .ex_opcode_i(ex_opcode), .ex_rs_data_i(ex_rs_data),
    .ex_pc_i(ex_pc), .ex_pred_taken_i(ex_pred_taken), .ex_stall_i(ex_stall),
    .clr_stats_i(clr_stats), .res_valid_o(res_valid), .res_taken_o(res_taken),
    .res_mispredict_o(res_mis), .br_count_o(br_count), .mis_count_o(mis_count)
  );

  branch_predict_unit #(.DATA_W(16), .IDX_W(4), .CNT_W(2), .INIT_STATE(2'b01)) dut2 (
    .clk_i(clk), .rst_i(rst), .fet_pc_i(fet_pc), .pred_taken_o(pred_taken2),
    .ex_valid_i(ex_valid), .ex_opcode_i(ex_opcode), .ex_rs_data_i(ex_rs_data),
    .ex_pc_i(ex_pc), .ex_pred_taken_i(ex_pred_taken), .ex_stall_i(ex_stall),
    .clr_stats_i(clr_stats), .res_valid_o(res_valid2), .res_taken_o(res_taken2),
    .res_mispredict_o(res_mis2), .br_count_o(br_count2), .mis_count_o(mis_count2)
  );

  typedef struct packed {
    logic        v;
    logic        t;
    logic        m;
    logic [15:0] br;
    logic [15:0] mis;
    logic [1:0]  br2;
    logic [1:0]  mis2;
  } exp_t;

  exp_t        sb[$];
  logic [1:0]  mdl [16];
  int          m_br, m_mis, m_br2, m_mis2;
  int          n_vec = 0;
  int          n_err = 0;

  function automatic logic outcome(input logic [4:0] op, input logic [15:0] rs);
    case (op)
      OP_BEQZ: return rs == 16'h0000;
      OP_BNEZ: return rs != 16'h0000;
      OP_BLTZ: return $signed(rs) < 0;
      default: return $signed(rs) >= 0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) mdl[i] = 2'b01;
    m_br = 0; m_mis = 0; m_br2 = 0; m_mis2 = 0;
  endtask

  // One clock cycle: drive inputs, check the combinational prediction against the
  // pre-update model, push the expected registered results, then pop and compare.
  task automatic step(input string tag, input logic r, input logic clr, input logic v,
                      input logic [4:0] op, input logic [15:0] rs, input logic [15:0] pc,
                      input logic pr, input logic stall, input logic [15:0] fpc);
    exp_t e;
    logic res, tk;
    int   ix;
    rst = r; clr_stats = clr; ex_valid = v; ex_opcode = op; ex_rs_data = rs;
    ex_pc = pc; ex_pred_taken = pr; ex_stall = stall; fet_pc = fpc;
    #1;
    chk({tag, ".pred"}, {31'd0, pred_taken}, {31'd0, mdl[fpc[4:1]][1]});

    res = v && !stall && (op == OP_BEQZ || op == OP_BNEZ || op == OP_BLTZ || op == OP_BGEZ);
    tk  = outcome(op, rs);
    if (r) begin
      model_reset();
      e.v = 1'b0; e.t = 1'b0; e.m = 1'b0;
    end else begin
      e.v = res;
      e.t = res && tk;
      e.m = res && (tk != pr);
      if (res) begin
        ix = int'(pc[4:1]);
        if (tk && mdl[ix] != 2'b11) mdl[ix] = mdl[ix] + 2'b01;
        else if (!tk && mdl[ix] != 2'b00) mdl[ix] = mdl[ix] - 2'b01;
      end
      if (clr) begin
        m_br = 0; m_mis = 0; m_br2 = 0; m_mis2 = 0;
      end else if (res) begin
        if (m_br < 65535) m_br++;
        if (m_br2 < 3) m_br2++;
        if (tk != pr) begin
          if (m_mis < 65535) m_mis++;
          if (m_mis2 < 3) m_mis2++;
        end
      end
    end
    e.br = 16'(m_br); e.mis = 16'(m_mis); e.br2 = 2'(m_br2); e.mis2 = 2'(m_mis2);
    sb.push_back(e);

    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk({tag, ".res_valid"}, {31'd0, res_valid}, {31'd0, e.v});
    chk({tag, ".res_taken"}, {31'd0, res_taken}, {31'd0, e.t});
    chk({tag, ".res_mis"},   {31'd0, res_mis},   {31'd0, e.m});
    chk({tag, ".br_count"},  {16'd0, br_count},  {16'd0, e.br});
    chk({tag, ".mis_count"}, {16'd0, mis_count}, {16'd0, e.mis});
    chk({tag, ".br_count2"}, {30'd0, br_count2}, {30'd0, e.br2});
    chk({tag, ".mis_count2"},{30'd0, mis_count2},{30'd0, e.mis2});
  endtask

  task automatic br(input string tag, input logic [4:0] op, input logic [15:0] rs,
                    input logic [15:0] pc, input logic pr);
    step(tag, 1'b0, 1'b0, 1'b1, op, rs, pc, pr, 1'b0, pc);
  endtask

  task automatic idle(input string tag, input logic [15:0] fpc);
    step(tag, 1'b0, 1'b0, 1'b0, 5'd0, 16'h0, 16'h0, 1'b0, 1'b0, fpc);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; clr_stats = 1'b0; ex_valid = 1'b0; ex_opcode = 5'd0; ex_rs_data = 16'h0;
    ex_pc = 16'h0; ex_pred_taken = 1'b0; ex_stall = 1'b0; fet_pc = 16'h0;
    model_reset();
    @(posedge clk); #1;

    // reset state
    step("reset", 1'b1, 1'b0, 1'b0, 5'd0, 16'h0, 16'h0, 1'b0, 1'b0, 16'h0004);

    // BEQZ taken against a not-taken prediction
    br("beqz_zero", OP_BEQZ, 16'h0000, 16'h0004, 1'b0);
    idle("beqz_after", 16'h0004);

    // sign-bit conditions, then a non-branch opcode
    br("bltz_neg",  OP_BLTZ, 16'h8000, 16'h0010, 1'b0);
    br("bgez_pos",  OP_BGEZ, 16'h7FFF, 16'h0012, 1'b1);
    br("bltz_one",  OP_BLTZ, 16'h0001, 16'h0014, 1'b0);
    br("bnez_zero", OP_BNEZ, 16'h0000, 16'h0016, 1'b1);
    step("not_branch", 1'b0, 1'b0, 1'b1, 5'b00000, 16'h0000, 16'h0018, 1'b1, 1'b0, 16'h0018);

    // saturation at strongly taken, then one step down
    for (int i = 0; i < 5; i++) br("sat_taken", OP_BNEZ, 16'h0005, 16'h0020, 1'b1);
    br("sat_nt", OP_BGEZ, 16'h8000, 16'h0020, 1'b1);
    idle("sat_pred", 16'h0020);
    idle("other_idx4", 16'h0004);
    idle("other_idx10", 16'h0010);
    idle("other_idx12", 16'h0014);

    // same-cycle lookup and update of one index: no bypass
    step("same_idx", 1'b0, 1'b0, 1'b1, OP_BEQZ, 16'h0000, 16'h0006, 1'b0, 1'b0, 16'h0006);
    idle("same_idx_next", 16'h0006);

    // stalled execute: no training, no stats, no result pulse
    br("pre_stall", OP_BEQZ, 16'h0000, 16'h000E, 1'b0);
    step("stall", 1'b0, 1'b0, 1'b1, OP_BEQZ, 16'h0000, 16'h0008, 1'b0, 1'b1, 16'h0008);
    step("stall2", 1'b0, 1'b0, 1'b1, OP_BEQZ, 16'h0000, 16'h0008, 1'b0, 1'b1, 16'h0008);
    idle("stall_after", 16'h0008);

    // counter saturation on the 2-bit build, clear priority
    step("clr", 1'b0, 1'b1, 1'b0, 5'd0, 16'h0, 16'h0, 1'b0, 1'b0, 16'h000A);
    for (int i = 0; i < 4; i++) br("cnt_sat", OP_BEQZ, 16'h0001, 16'h000A, 1'b1);
    step("clr_and_res", 1'b0, 1'b1, 1'b1, OP_BEQZ, 16'h0000, 16'h000C, 1'b0, 1'b0, 16'h000C);

    // reset after a resolve, and reset dropping a same-cycle resolve
    br("pre_rst", OP_BEQZ, 16'h0000, 16'h0020, 1'b0);
    step("rst_drop", 1'b1, 1'b0, 1'b1, OP_BEQZ, 16'h0000, 16'h0020, 1'b0, 1'b0, 16'h0020);
    idle("rst_init", 16'h0020);
    br("init_nt", OP_BLTZ, 16'h0001, 16'h0020, 1'b0);
    br("init_t",  OP_BEQZ, 16'h0000, 16'h0020, 1'b0);
    idle("init_chk", 16'h0020);
    br("init_t2", OP_BEQZ, 16'h0000, 16'h0020, 1'b0);
    idle("init_chk2", 16'h0020);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
